// File: rtl/wram_xfer_engine.sv
// WRAM window copy engine: moves SIZE bytes between a byte stream and WRAM through the toggle-style RV request port.
// Build macro WRAM_XFER_CHECKSUM_EN adds a 16-bit wrapping byte sum on o_checksum (tied to zero otherwise).
module wram_xfer_engine #(
    parameter logic [22:0] BASE_ADDR = 23'h706000,
    parameter int          SIZE      = 'h2000,
    parameter int          CNT_W     = 14
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_dir_save,
    input  logic        i_abort,
    input  logic [7:0]  i_in_data,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    output logic [7:0]  o_out_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [22:0] o_rv_addr,
    output logic        o_rv_word,
    output logic [31:0] o_rv_wdata,
    output logic [1:0]  o_rv_ds,
    output logic [3:0]  o_rv_wstrb,
    output logic        o_rv_req,
    input  logic        i_rv_req_ack,
    input  logic [15:0] i_rv_dout,
    output logic        o_wram_load_ongoing,
    output logic        o_wram_save_ongoing,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_checksum,
    output logic [2:0]  o_state
);

    // Stream handshakes: a byte moves at the clock edge where valid && ready are both high;
    // o_out_valid holds with stable o_out_data until i_out_ready (only an abort withdraws it).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_FETCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_EMIT  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] idx;
    logic             dir_save;
    logic             err_r;
    logic             rv_req;
    logic [7:0]       byte_r;
    logic [22:0]      rv_addr;
    logic [31:0]      rv_wdata;
    logic [1:0]       rv_ds;
    logic [3:0]       rv_wstrb;
    logic             req_done;
    logic             last_idx;
    logic             idx_inc;
    logic             xfer;
    logic [7:0]       rd_byte;

    assign req_done = (i_rv_req_ack == rv_req);
    assign last_idx = (idx == CNT_W'(SIZE - 1));
    assign rd_byte  = idx[0] ? i_rv_dout[15:8] : i_rv_dout[7:0];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_start) state_nxt = i_dir_save ? S_ISSUE : S_FETCH;
            S_SYNC:  state_nxt = S_IDLE;
            S_FETCH: begin
                if (i_abort)         state_nxt = S_DONE;
                else if (i_in_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = i_abort ? S_DONE : S_WAIT;
            // An abort never cuts a request short: the ack is always collected first.
            S_WAIT: begin
                if (req_done) begin
                    if (i_abort)       state_nxt = S_DONE;
                    else if (dir_save) state_nxt = S_EMIT;
                    else if (last_idx) state_nxt = S_DONE;
                    else               state_nxt = S_FETCH;
                end
            end
            S_EMIT: begin
                if (i_abort)          state_nxt = S_DONE;
                else if (i_out_ready) state_nxt = last_idx ? S_DONE : S_ISSUE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign idx_inc = ((state == S_WAIT) && (state_nxt == S_FETCH)) ||
                     ((state == S_EMIT) && (state_nxt == S_ISSUE));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idx      <= '0;
            dir_save <= 1'b0;
            err_r    <= 1'b0;
            rv_req   <= 1'b0;
            byte_r   <= 8'h00;
            rv_addr  <= 23'h0;
            rv_wdata <= 32'h0;
            rv_ds    <= 2'b00;
            rv_wstrb <= 4'b0000;
        end else begin
            if (state == S_SYNC) begin
                rv_req <= i_rv_req_ack;
            end
            if ((state == S_IDLE) && i_start) begin
                dir_save <= i_dir_save;
                idx      <= '0;
                err_r    <= 1'b0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if ((state_nxt == S_DONE) && (state != S_DONE) && i_abort) begin
                err_r <= 1'b1;
            end
            if ((state == S_FETCH) && !i_abort && i_in_valid) begin
                byte_r <= i_in_data;
            end
            if ((state == S_WAIT) && req_done && dir_save) begin
                byte_r <= rd_byte;
            end
            // Request fields are only written here, so they stay put until the ack.
            if ((state == S_ISSUE) && !i_abort) begin
                rv_req   <= ~rv_req;
                rv_addr  <= BASE_ADDR + 23'(idx);
                rv_wdata <= {4{byte_r}};
                rv_ds    <= idx[0] ? 2'b10 : 2'b01;
                rv_wstrb <= dir_save ? 4'b0000 : (4'b0001 << idx[1:0]);
            end
        end
    end

`ifdef WRAM_XFER_CHECKSUM_EN
    logic [15:0] csum;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csum <= 16'h0000;
        end else if ((state == S_IDLE) && i_start) begin
            csum <= 16'h0000;
        end else if ((state == S_FETCH) && !i_abort && i_in_valid) begin
            csum <= csum + {8'h00, i_in_data};
        end else if ((state == S_WAIT) && req_done && dir_save) begin
            csum <= csum + {8'h00, rd_byte};
        end
    end

    assign o_checksum = csum;
`else
    assign o_checksum = 16'h0000;
`endif

    // SYNC counts as not busy so every output reads zero coming out of reset.
    assign xfer                = (state == S_FETCH) || (state == S_ISSUE) ||
                                 (state == S_WAIT)  || (state == S_EMIT);
    assign o_busy              = (state != S_IDLE) && (state != S_SYNC);
    assign o_in_ready          = (state == S_FETCH) && !i_abort;
    assign o_out_valid         = (state == S_EMIT) && !i_abort;
    assign o_out_data          = byte_r;
    assign o_wram_load_ongoing = xfer && !dir_save;
    assign o_wram_save_ongoing = xfer && dir_save;
    assign o_done              = (state == S_DONE);
    assign o_error             = (state == S_DONE) && err_r;
    assign o_rv_req            = rv_req;
    assign o_rv_addr           = rv_addr;
    assign o_rv_word           = rv_addr[1];
    assign o_rv_wdata          = rv_wdata;
    assign o_rv_ds             = rv_ds;
    assign o_rv_wstrb          = rv_wstrb;
    assign o_state             = state;

endmodule

// File: tb/tb_wram_xfer_engine.sv
// Directed bench for wram_xfer_engine: RV responder, stream source/sink, protocol monitor and per-scenario tasks.
module tb_wram_xfer_engine;

  localparam int NBYTES = 'h2000;
  localparam logic [22:0] BASE = 23'h706000;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [60:0] SAVE_MASK = {23'h7FFFFF, 4'hF, 32'h0, 2'b11};
`ifdef WRAM_XFER_CHECKSUM_EN
  localparam logic [15:0] EXP_SUM = 16'hF000;
`else
  localparam logic [15:0] EXP_SUM = 16'h0000;
`endif

  logic        i_clk, i_reset, i_start, i_dir_save, i_abort;
  logic [7:0]  i_in_data;
  logic        i_in_valid, o_in_ready;
  logic [7:0]  o_out_data;
  logic        o_out_valid, i_out_ready;
  logic [22:0] o_rv_addr;
  logic        o_rv_word;
  logic [31:0] o_rv_wdata;
  logic [1:0]  o_rv_ds;
  logic [3:0]  o_rv_wstrb;
  logic        o_rv_req, i_rv_req_ack;
  logic [15:0] i_rv_dout;
  logic        o_wram_load_ongoing, o_wram_save_ongoing, o_busy, o_done, o_error;
  logic [15:0] o_checksum;
  logic [2:0]  o_state;

  wram_xfer_engine dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_dir_save(i_dir_save),
    .i_abort(i_abort), .i_in_data(i_in_data), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .o_out_data(o_out_data), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_rv_addr(o_rv_addr), .o_rv_word(o_rv_word), .o_rv_wdata(o_rv_wdata), .o_rv_ds(o_rv_ds),
    .o_rv_wstrb(o_rv_wstrb), .o_rv_req(o_rv_req), .i_rv_req_ack(i_rv_req_ack),
    .i_rv_dout(i_rv_dout), .o_wram_load_ongoing(o_wram_load_ongoing),
    .o_wram_save_ongoing(o_wram_save_ongoing), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_checksum(o_checksum), .o_state(o_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // ---------------- shared control (written only by test tasks) ----------------
  int   ack_delay = 1;
  logic reset_ack = 1'b0;
  int   src_gap = 0;
  bit   src_en = 1'b0;
  int   src_gen = 0;
  int   sink_stall_until = 0;

  // ---------------- logs ----------------
  logic [60:0] log_q[$];
  logic        reqv_q[$];
  logic [7:0]  out_q[$];
  logic [60:0] exp_q[$];

  // ---------------- RV responder ----------------
  initial begin : responder
    logic [22:0] a;
    i_rv_req_ack = 1'b0;
    i_rv_dout = 16'h0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        i_rv_req_ack = reset_ack;
      end else if (o_busy && (o_rv_req !== i_rv_req_ack)) begin
        log_q.push_back({o_rv_addr, o_rv_wstrb, o_rv_wdata, o_rv_ds});
        reqv_q.push_back(o_rv_req);
        a = o_rv_addr;
        for (int k = 1; k < ack_delay; k++) @(negedge i_clk);
        i_rv_dout = {a[7:1], 1'b1, a[7:1], 1'b0};
        i_rv_req_ack = o_rv_req;
      end
    end
  end

  // ---------------- load-stream source: bytes 0,1,2,... ----------------
  int src_idx = 0;
  initial begin : source
    int my_gen;
    int gap_cnt;
    bit acc_pending;
    my_gen = 0; gap_cnt = 0; acc_pending = 1'b0;
    i_in_valid = 1'b0;
    i_in_data = 8'h00;
    forever begin
      @(negedge i_clk);
      if (my_gen != src_gen) begin
        my_gen = src_gen; src_idx = 0; i_in_valid = 1'b0; acc_pending = 1'b0; gap_cnt = 0;
      end
      if (acc_pending) begin
        src_idx++; i_in_valid = 1'b0; gap_cnt = src_gap; acc_pending = 1'b0;
      end
      if (!src_en) begin
        i_in_valid = 1'b0;
      end else if (!i_in_valid) begin
        if (gap_cnt > 0) gap_cnt--;
        else begin
          i_in_valid = 1'b1;
          i_in_data = src_idx[7:0];
        end
      end
      if (i_in_valid && o_in_ready) acc_pending = 1'b1;
    end
  end

  // ---------------- save-stream sink: stalls 5 cycles per byte while below sink_stall_until ----------------
  initial begin : sink
    int stall_cnt;
    stall_cnt = 0;
    i_out_ready = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_out_valid) begin
        if ((out_q.size() < sink_stall_until) && (stall_cnt < 5)) begin
          i_out_ready = 1'b0;
          stall_cnt++;
        end else begin
          i_out_ready = 1'b1;
        end
      end else begin
        i_out_ready = 1'b0;
      end
      if (o_out_valid && i_out_ready) begin
        out_q.push_back(o_out_data);
        stall_cnt = 0;
      end
    end
  end

  // ---------------- protocol monitor ----------------
  int cyc = 0, done_cyc = -1, last_ack_cyc = -1, done_cnt = 0;
  int viol_outst = 0, viol_stable = 0, viol_ready = 0, viol_addr = 0;
  int viol_both = 0, viol_req_ov = 0, viol_ov_drop = 0;
  initial begin : monitor
    logic        p_req, p_ack, p_ov, p_ordy, p_abort, p_busy;
    logic [60:0] p_fields;
    logic [7:0]  p_od;
    logic        tog;
    p_req = 0; p_ack = 0; p_ov = 0; p_ordy = 0; p_abort = 0; p_busy = 0; p_fields = '0; p_od = 0;
    forever begin
      @(negedge i_clk);
      #1;
      cyc++;
      if (!i_reset) begin
        tog = (o_rv_req !== p_req);
        if (tog && o_busy) begin
          if (p_req !== p_ack) viol_outst++;
          if (p_ov && !p_ordy) viol_req_ov++;
        end
        if (!tog && p_busy && (p_req !== p_ack) &&
            ({o_rv_addr, o_rv_wstrb, o_rv_wdata, o_rv_ds} !== p_fields)) viol_stable++;
        if (o_in_ready && (o_state !== ST_FETCH)) viol_ready++;
        if (o_busy && (o_rv_req !== i_rv_req_ack) &&
            ((o_rv_addr < BASE) || (o_rv_addr > BASE + 23'(NBYTES - 1)))) viol_addr++;
        if (o_wram_load_ongoing && o_wram_save_ongoing) viol_both++;
        if (p_ov && !p_ordy && !p_abort && (!o_out_valid || (o_out_data !== p_od))) viol_ov_drop++;
        if (i_rv_req_ack !== p_ack) last_ack_cyc = cyc;
        if (o_done === 1'b1) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
      p_req = o_rv_req; p_ack = i_rv_req_ack; p_ov = o_out_valid; p_ordy = i_out_ready;
      p_abort = i_abort; p_busy = o_busy; p_od = o_out_data;
      p_fields = {o_rv_addr, o_rv_wstrb, o_rv_wdata, o_rv_ds};
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(negedge i_clk);
    #2;
  endtask

  task automatic pulse_start(input logic dir);
    i_dir_save = dir;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_dir_save = ~dir;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget; k++) begin
      tick();
      if (o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [60:0] exp_load(input int i);
    logic [22:0] a;
    logic [7:0]  b;
    logic [3:0]  s;
    a = BASE + 23'(i);
    b = i[7:0];
    s = 4'b0001 << i[1:0];
    return {a, s, {4{b}}, (i[0] ? 2'b10 : 2'b01)};
  endfunction

  function automatic logic [60:0] exp_save(input int i);
    logic [22:0] a;
    a = BASE + 23'(i);
    return {a, 4'b0000, 32'h0, (i[0] ? 2'b10 : 2'b01)};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [79:0] got;
    reset_ack = 1'b1;
    i_reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    got = {o_rv_req, o_busy, o_done, o_error, o_in_ready, o_out_valid, o_wram_load_ongoing,
           o_wram_save_ongoing, o_rv_addr, o_rv_wstrb, o_rv_wdata, o_checksum};
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", got);
    end
    i_reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_rv_req !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_req: o_rv_req=%b required 1", o_rv_req);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_busy: o_busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_load_full();
    int lb, bad;
    bit seen;
    lb = log_q.size();
    ack_delay = 1; src_gap = 0; src_gen++; src_en = 1'b1;
    tick();
    pulse_start(1'b0);
    n_checks++;
    if ({o_wram_load_ongoing, o_wram_save_ongoing, o_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL load_flags: {load,save,busy}=%b required 101", {o_wram_load_ongoing, o_wram_save_ongoing, o_busy});
    end
    wait_done(30000, seen);
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL load_done_timeout: no o_done within 30000 cycles");
    end
    n_checks++;
    if ({o_error, o_wram_load_ongoing, o_wram_save_ongoing} !== 3'b000) begin
      n_fail++;
      $display("FAIL load_done_state: {err,load,save}=%b required 000", {o_error, o_wram_load_ongoing, o_wram_save_ongoing});
    end
    n_checks++;
    if (done_cyc !== last_ack_cyc + 1) begin
      n_fail++;
      $display("FAIL load_done_latency: done at %0d, last ack at %0d, required ack+1", done_cyc, last_ack_cyc);
    end
    n_checks++;
    if (o_checksum !== EXP_SUM) begin
      n_fail++;
      $display("FAIL load_checksum: got %h required %h", o_checksum, EXP_SUM);
    end
    src_en = 1'b0;
    tick();
    n_checks++;
    if (o_checksum !== EXP_SUM) begin
      n_fail++;
      $display("FAIL load_checksum_hold: got %h required %h", o_checksum, EXP_SUM);
    end
    n_checks++;
    if (log_q.size() - lb !== NBYTES) begin
      n_fail++;
      $display("FAIL load_req_count: got %0d required %0d", log_q.size() - lb, NBYTES);
    end
    n_checks++;
    if ((log_q.size() > lb) && (reqv_q[lb] !== 1'b0)) begin
      n_fail++;
      $display("FAIL first_toggle: first req=%b required 0", reqv_q[lb]);
    end
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(exp_load(i));
    bad = 0;
    for (int i = 0; i < NBYTES && (lb + i) < log_q.size(); i++) begin
      logic [60:0] e;
      e = exp_q.pop_front();
      n_checks++;
      if (log_q[lb + i] !== e) begin
        n_fail++;
        $display("FAIL load_req[%0d]: got %h required %h", i, log_q[lb + i], e);
        bad = 1;
        break;
      end
    end
    exp_q.delete();
    n_checks++;
    if ((viol_outst + viol_stable + viol_ready + viol_addr + viol_both) !== 0) begin
      n_fail++;
      $display("FAIL load_protocol: outst=%0d stable=%0d ready=%0d addr=%0d both=%0d required 0",
               viol_outst, viol_stable, viol_ready, viol_addr, viol_both);
    end
  endtask

  task automatic test_save_full();
    int lb, ob;
    bit seen;
    lb = log_q.size();
    ob = out_q.size();
    sink_stall_until = ob + 256;
    ack_delay = 1;
    pulse_start(1'b1);
    n_checks++;
    if ({o_wram_load_ongoing, o_wram_save_ongoing} !== 2'b01) begin
      n_fail++;
      $display("FAIL save_flags: {load,save}=%b required 01", {o_wram_load_ongoing, o_wram_save_ongoing});
    end
    wait_done(40000, seen);
    n_checks++;
    if (!seen || (o_error !== 1'b0)) begin
      n_fail++;
      $display("FAIL save_done: seen=%b err=%b required 1/0", seen, o_error);
    end
    n_checks++;
    if (o_checksum !== EXP_SUM) begin
      n_fail++;
      $display("FAIL save_checksum: got %h required %h", o_checksum, EXP_SUM);
    end
    n_checks++;
    if ((out_q.size() - ob !== NBYTES) || (log_q.size() - lb !== NBYTES)) begin
      n_fail++;
      $display("FAIL save_count: bytes %0d reqs %0d required %0d", out_q.size() - ob, log_q.size() - lb, NBYTES);
    end
    for (int i = 0; i < NBYTES && (ob + i) < out_q.size(); i++) begin
      logic [7:0] e;
      e = i[7:0];
      n_checks++;
      if (out_q[ob + i] !== e) begin
        n_fail++;
        $display("FAIL save_byte[%0d]: got %h required %h", i, out_q[ob + i], e);
        break;
      end
    end
    for (int i = 0; i < NBYTES && (lb + i) < log_q.size(); i++) begin
      n_checks++;
      if ((log_q[lb + i] & SAVE_MASK) !== exp_save(i)) begin
        n_fail++;
        $display("FAIL save_req[%0d]: got %h required %h", i, log_q[lb + i] & SAVE_MASK, exp_save(i));
        break;
      end
    end
    n_checks++;
    if ((viol_req_ov + viol_ov_drop + viol_outst + viol_stable) !== 0) begin
      n_fail++;
      $display("FAIL save_protocol: req_ov=%0d ov_drop=%0d outst=%0d stable=%0d required 0",
               viol_req_ov, viol_ov_drop, viol_outst, viol_stable);
    end
  endtask

  task automatic test_start_ignored();
    int lb, n;
    bit seen;
    lb = log_q.size();
    ack_delay = 1; src_gap = 0; src_gen++; src_en = 1'b1;
    tick();
    pulse_start(1'b0);
    for (int k = 0; k < 3; k++) begin
      repeat (7) tick();
      pulse_start(1'b1);
    end
    for (int k = 0; k < 200 && (log_q.size() - lb) < 12; k++) tick();
    i_abort = 1'b1;
    wait_done(50, seen);
    i_abort = 1'b0;
    src_en = 1'b0;
    n = log_q.size() - lb;
    n_checks++;
    if (!seen || (o_error !== 1'b1)) begin
      n_fail++;
      $display("FAIL busy_start_done: seen=%b err=%b required 1/1", seen, o_error);
    end
    n_checks++;
    if ((n < 12) || (n > 13)) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d required 12..13", n);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (log_q[lb + i] !== exp_load(i)) begin
        n_fail++;
        $display("FAIL busy_start_req[%0d]: got %h required %h", i, log_q[lb + i], exp_load(i));
        break;
      end
    end
    n_checks++;
    if (viol_both !== 0) begin
      n_fail++;
      $display("FAIL busy_start_flags: both-flags cycles %0d required 0", viol_both);
    end
  endtask

  task automatic test_abort_wait();
    int lb;
    bit seen;
    lb = log_q.size();
    ack_delay = 10; src_gap = 0; src_gen++; src_en = 1'b1;
    tick();
    pulse_start(1'b0);
    for (int k = 0; k < 20 && (o_rv_req === i_rv_req_ack); k++) tick();
    n_checks++;
    if ((o_rv_req === i_rv_req_ack) || (o_wram_load_ongoing !== 1'b1)) begin
      n_fail++;
      $display("FAIL abort_wait_setup: outstanding=%b load=%b required 1/1", o_rv_req !== i_rv_req_ack, o_wram_load_ongoing);
    end
    i_abort = 1'b1;
    wait_done(50, seen);
    n_checks++;
    if (!seen || (o_error !== 1'b1)) begin
      n_fail++;
      $display("FAIL abort_wait_done: seen=%b err=%b required 1/1", seen, o_error);
    end
    n_checks++;
    if (done_cyc !== last_ack_cyc + 1) begin
      n_fail++;
      $display("FAIL abort_wait_latency: done at %0d, ack at %0d, required ack+1", done_cyc, last_ack_cyc);
    end
    n_checks++;
    if ({o_wram_load_ongoing, o_wram_save_ongoing} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_wait_flags: {load,save}=%b required 00", {o_wram_load_ongoing, o_wram_save_ongoing});
    end
    i_abort = 1'b0;
    src_en = 1'b0;
    repeat (5) tick();
    n_checks++;
    if ((log_q.size() - lb !== 1) || (log_q[lb] !== exp_load(0))) begin
      n_fail++;
      $display("FAIL abort_wait_reqs: count %0d required 1 with fields %h", log_q.size() - lb, exp_load(0));
    end
    ack_delay = 1;
  endtask

  task automatic test_gap_abort_fetch();
    int lb, n;
    lb = log_q.size();
    ack_delay = 1; src_gap = 3; src_gen++; src_en = 1'b1;
    tick();
    pulse_start(1'b0);
    for (int k = 0; k < 500 && (log_q.size() - lb) < 20; k++) tick();
    for (int k = 0; k < 20 && !(o_in_ready && !i_in_valid); k++) tick();
    i_abort = 1'b1;
    n = log_q.size() - lb;
    tick();
    n_checks++;
    if ({o_done, o_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL fetch_abort_done: {done,err}=%b required 11", {o_done, o_error});
    end
    i_abort = 1'b0;
    src_en = 1'b0;
    src_gap = 0;
    repeat (3) tick();
    n_checks++;
    if ((n < 20) || (log_q.size() - lb !== n)) begin
      n_fail++;
      $display("FAIL fetch_abort_count: before %0d after %0d required >=20 and unchanged", n, log_q.size() - lb);
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (log_q[lb + i] !== exp_load(i)) begin
        n_fail++;
        $display("FAIL gap_req[%0d]: got %h required %h", i, log_q[lb + i], exp_load(i));
        break;
      end
    end
    n_checks++;
    if (viol_ready !== 0) begin
      n_fail++;
      $display("FAIL gap_ready: in_ready outside FETCH %0d times required 0", viol_ready);
    end
  endtask

  task automatic test_start_abort_same();
    int lb;
    lb = log_q.size();
    src_gen++; src_en = 1'b1;
    tick();
    i_abort = 1'b1;
    pulse_start(1'b0);
    n_checks++;
    if ({o_busy, o_done, o_in_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL start_abort_first: {busy,done,in_ready}=%b required 100", {o_busy, o_done, o_in_ready});
    end
    tick();
    n_checks++;
    if ({o_done, o_error} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_abort_done: {done,err}=%b required 11", {o_done, o_error});
    end
    n_checks++;
    if (o_checksum !== 16'h0000) begin
      n_fail++;
      $display("FAIL start_abort_checksum: got %h required 0000", o_checksum);
    end
    i_abort = 1'b0;
    src_en = 1'b0;
    tick();
    n_checks++;
    if ((log_q.size() !== lb) || (o_busy !== 1'b0)) begin
      n_fail++;
      $display("FAIL start_abort_idle: reqs %0d busy %b required 0/0", log_q.size() - lb, o_busy);
    end
  endtask

  task automatic test_reset_mid();
    int dc;
    src_gen++; src_en = 1'b1;
    tick();
    pulse_start(1'b0);
    repeat (6) tick();
    dc = done_cnt;
    i_reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({o_busy, o_done, o_wram_load_ongoing} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid: {busy,done,load}=%b required 000", {o_busy, o_done, o_wram_load_ongoing});
    end
    i_reset = 1'b0;
    src_en = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ((done_cnt !== dc) || (o_busy !== 1'b0) || (o_rv_req !== reset_ack)) begin
      n_fail++;
      $display("FAIL reset_mid_after: done pulses %0d busy %b req %b required 0/0/%b",
               done_cnt - dc, o_busy, o_rv_req, reset_ack);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_dir_save = 1'b0;
    i_abort = 1'b0;
    test_reset();
    test_load_full();
    test_save_full();
    test_start_ignored();
    test_abort_wait();
    test_gap_abort_fetch();
    test_start_abort_same();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
